// File: rtl/iq_phase_freq_meter.sv
// rtl/iq_phase_freq_meter.sv - I/Q to phase and phase-increment meter using a vectoring CORDIC
// One sample in flight at a time; results are registered on the last micro-rotation and strobed in OUT.
module iq_phase_freq_meter #(
   parameter int IW   = 17,
   parameter int PW   = 32,
   parameter int ITER = 16,
   parameter int GW   = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clken,
   input  logic          in_valid,
   input  logic [IW-1:0] i_in,
   input  logic [IW-1:0] q_in,
   output logic          in_ready,
   output logic          out_valid,
   output logic [PW-1:0] phase_o,
   output logic [PW-1:0] dphi_o,
   output logic          dphi_valid,
   output logic          zero_o
);

   localparam int W  = IW + GW;
   localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {IDLE, PRE, ROT, OUT} state_t;

   state_t                state, state_nxt;
   logic                  armed;
   logic signed [W-1:0]   x, y, x_nxt, y_nxt;
   logic [PW-1:0]         z, z_nxt;
   logic [KW-1:0]         k, k_nxt;
   logic                  zero_lat, zero_nxt;
   logic                  fin;
   logic [PW-1:0]         prev;
   logic                  have_prev;
   logic [31:0]           a32;
   logic [PW-1:0]         atan_k;

   // atan(2^-k) scaled so that 2^32 is one full turn; narrower PW keeps the top bits
   always_comb begin
      a32 = 32'h0000_0000;
      case (k)
         4'd0:    a32 = 32'h2000_0000;
         4'd1:    a32 = 32'h12E4_051E;
         4'd2:    a32 = 32'h09FB_385B;
         4'd3:    a32 = 32'h0511_11D4;
         4'd4:    a32 = 32'h028B_0D43;
         4'd5:    a32 = 32'h0145_D7E1;
         4'd6:    a32 = 32'h00A2_F61E;
         4'd7:    a32 = 32'h0051_7C55;
         4'd8:    a32 = 32'h0028_BE53;
         4'd9:    a32 = 32'h0014_5F2F;
         4'd10:   a32 = 32'h000A_2F98;
         4'd11:   a32 = 32'h0005_17CC;
         4'd12:   a32 = 32'h0002_8BE6;
         4'd13:   a32 = 32'h0001_45F3;
         4'd14:   a32 = 32'h0000_A2FA;
         4'd15:   a32 = 32'h0000_517D;
         default: a32 = 32'h0000_0000;
      endcase
   end

   assign atan_k    = a32[31 -: PW];
   assign in_ready  = (state == IDLE) & clken & armed;
   assign out_valid = (state == OUT) & clken;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else if (clken) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      z_nxt     = z;
      k_nxt     = k;
      zero_nxt  = zero_lat;
      fin       = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               x_nxt     = {{GW{i_in[IW-1]}}, i_in};
               y_nxt     = {{GW{q_in[IW-1]}}, q_in};
               zero_nxt  = (i_in == '0) && (q_in == '0);
               state_nxt = PRE;
            end
         end
         PRE: begin
            // Fold the left half-plane onto the right so the rotations converge
            if (x[W-1]) begin
               x_nxt = -x;
               y_nxt = -y;
               z_nxt = {1'b1, {(PW-1){1'b0}}};
            end else begin
               z_nxt = '0;
            end
            k_nxt     = '0;
            state_nxt = ROT;
         end
         ROT: begin
            if (!y[W-1]) begin
               x_nxt = x + (y >>> k);
               y_nxt = y - (x >>> k);
               z_nxt = z + atan_k;
            end else begin
               x_nxt = x - (y >>> k);
               y_nxt = y + (x >>> k);
               z_nxt = z - atan_k;
            end
            k_nxt = k + 1'b1;
            if (k == KW'(ITER - 1)) begin
               fin       = 1'b1;
               state_nxt = OUT;
            end
         end
         OUT: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed    <= 1'b0;
         x        <= '0;
         y        <= '0;
         z        <= '0;
         k        <= '0;
         zero_lat <= 1'b0;
      end else if (clken) begin
         armed    <= 1'b1;
         x        <= x_nxt;
         y        <= y_nxt;
         z        <= z_nxt;
         k        <= k_nxt;
         zero_lat <= zero_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_o    <= '0;
         dphi_o     <= '0;
         dphi_valid <= 1'b0;
         zero_o     <= 1'b0;
         prev       <= '0;
         have_prev  <= 1'b0;
      end else if (clken && fin) begin
         if (zero_lat) begin
            // Undefined angle: report it but leave the running reference alone
            phase_o    <= '0;
            dphi_o     <= '0;
            dphi_valid <= 1'b0;
            zero_o     <= 1'b1;
         end else begin
            phase_o    <= z_nxt;
            dphi_o     <= z_nxt - prev;
            dphi_valid <= have_prev;
            zero_o     <= 1'b0;
            prev       <= z_nxt;
            have_prev  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_iq_phase_freq_meter.sv
// tb/tb_iq_phase_freq_meter.sv - self-checking bench for iq_phase_freq_meter
module tb_iq_phase_freq_meter;

   localparam real PI = 3.14159265358979323846;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clken = 1'b1;
   logic        in_valid = 1'b0;
   logic [16:0] i_in = '0;
   logic [16:0] q_in = '0;
   logic        in_ready, out_valid, dphi_valid, zero_o;
   logic [31:0] phase_o, dphi_o;

   iq_phase_freq_meter dut (
      .clk(clk), .reset_n(reset_n), .clken(clken), .in_valid(in_valid),
      .i_in(i_in), .q_in(q_in), .in_ready(in_ready), .out_valid(out_valid),
      .phase_o(phase_o), .dphi_o(dphi_o), .dphi_valid(dphi_valid), .zero_o(zero_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] phase;
      logic [31:0] dphi;
      bit          dv;
      bit          zero;
      bit          chk_apx;
      logic [31:0] apx;
      int          acc_en;
   } exp_t;

   typedef struct {
      int          i;
      int          q;
      logic [31:0] apx;
   } vec_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          en_cnt = 0;
   logic [31:0] m_prev = '0;
   bit          m_have = 1'b0;
   logic [31:0] atan_tab [16];
   bit          gate_en = 1'b0;
   bit          tone_mode = 1'b0;
   bit          spacing_chk = 1'b0;
   bit          prev_ov = 1'b0;
   int          last_acc = -1000;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic chk_near(input string name, input logic [31:0] act, input logic [31:0] req, input int tol);
      logic [31:0] d;
      int          sd;
      d  = act - req;
      sd = $signed(d);
      if (sd < 0) sd = -sd;
      n_cmp++;
      if (sd > tol) begin
         n_bad++;
         $display("FAIL %s: got %08h, required %08h +/- %0d", name, act, req, tol);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expected event did not occur within bound", name);
   endtask

   // Vectoring CORDIC from the algorithm description, in unbounded integers
   function automatic logic [31:0] ref_phase(input int i, input int q);
      longint      x, y, xt;
      logic [31:0] z;
      x = i;
      y = q;
      if (x < 0) begin
         x = -x;
         y = -y;
         z = 32'h8000_0000;
      end else begin
         z = '0;
      end
      for (int k = 0; k < 16; k++) begin
         xt = x;
         if (y >= 0) begin
            x = x + (y >>> k);
            y = y - (xt >>> k);
            z = z + atan_tab[k];
         end else begin
            x = x - (y >>> k);
            y = y + (xt >>> k);
            z = z - atan_tab[k];
         end
      end
      return z;
   endfunction

   function automatic logic [31:0] real_phase(input int i, input int q);
      real    a;
      longint t;
      a = $atan2(real'(q), real'(i));
      if (a < 0.0) a = a + 2.0 * PI;
      t = longint'(a * 4294967296.0 / (2.0 * PI));
      return t[31:0];
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (clken) en_cnt <= en_cnt + 1;
   end

   task automatic monitor_step();
      exp_t e;
      if (reset_n && exp_q.size() != 0 && !out_valid) chk("busy_ready", in_ready, 0);
      if (out_valid) begin
         chk("ov_clken", clken, 1);
         chk("ov_width", prev_ov, 0);
         if (exp_q.size() == 0) begin
            fail_now("unexpected_out_valid");
         end else begin
            e = exp_q.pop_front();
            chk("phase", phase_o, e.phase);
            chk("zero", zero_o, e.zero);
            chk("dphi_valid", dphi_valid, e.dv);
            chk("dphi", dphi_o, e.dphi);
            chk("latency", en_cnt - e.acc_en, 18);
            if (e.chk_apx) chk_near("phase_accuracy", phase_o, e.apx, 1 << 18);
            if (tone_mode && e.dv) chk_near("tone_dphi", dphi_o, 32'h6A40_0000, 1 << 19);
         end
      end
      prev_ov = out_valid;
   endtask

   always @(negedge clk) monitor_step();

   task automatic send(input int i, input int q, input bit hold, input bit apx_en, input logic [31:0] apx);
      exp_t e;
      int   tries;
      @(negedge clk);
      #1;
      i_in     = 17'(i);
      q_in     = 17'(q);
      in_valid = 1'b1;
      #1;
      tries = 0;
      while (!in_ready && tries < 600) begin
         @(negedge clk);
         #2;
         tries++;
      end
      if (!in_ready) begin
         fail_now("accept_timeout");
         in_valid = 1'b0;
         return;
      end
      if (spacing_chk) chk("accept_spacing", cyc + 1 - last_acc, 19);
      last_acc = cyc + 1;
      e.zero = (i == 0) && (q == 0);
      if (e.zero) begin
         e.phase = '0;
         e.dphi  = '0;
         e.dv    = 1'b0;
      end else begin
         e.phase = ref_phase(i, q);
         e.dphi  = e.phase - m_prev;
         e.dv    = m_have;
         m_prev  = e.phase;
         m_have  = 1'b1;
      end
      e.chk_apx = apx_en && !e.zero;
      e.apx     = apx;
      e.acc_en  = en_cnt;
      exp_q.push_back(e);
      if (!hold) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic quiet();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         fail_now("drain_timeout");
         exp_q.delete();
      end
   endtask

   task automatic rand_iq(output int i, output int q);
      i = int'($urandom_range(0, 131071)) - 65536;
      q = int'($urandom_range(0, 131071)) - 65536;
   endtask

   function automatic bit big_mag(input int i, input int q);
      longint m;
      m = longint'(i) * i + longint'(q) * q;
      return m >= (64'sd1 << 30);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [9];
      int          ri, rq;
      logic [31:0] p;

      for (int k = 0; k < 16; k++)
         atan_tab[k] = 32'(longint'($atan(2.0 ** (-k)) * 4294967296.0 / (2.0 * PI)));

      tbl = '{
         '{65535,  0,      32'h0000_0000},
         '{0,      65535,  32'h4000_0000},
         '{-65535, 0,      32'h8000_0000},
         '{0,      -65535, 32'hC000_0000},
         '{65535,  65535,  32'h2000_0000},
         '{0,      0,      32'h0000_0000},
         '{-65536, -65536, 32'hA000_0000},
         '{-65536, 0,      32'h8000_0000},
         '{65535,  -65536, 32'hE000_0000}
      };

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_phase", phase_o, 0);
      chk("rst_dphi", dphi_o, 0);
      chk("rst_dphi_valid", dphi_valid, 0);
      chk("rst_zero", zero_o, 0);
      #1 reset_n = 1'b1;
      #1 chk("ready_before_first_clk", in_ready, 0);
      @(negedge clk);
      chk("ready_after_release", in_ready, 1);

      // Table vectors: quadrants, zero, extremes
      for (int n = 0; n < 9; n++) begin
         send(tbl[n].i, tbl[n].q, 1'b0, 1'b1, tbl[n].apx);
         drain();
      end

      // Back-to-back handshake with in_valid held high
      spacing_chk = 1'b0;
      for (int n = 0; n < 5; n++) begin
         rand_iq(ri, rq);
         send(ri, rq, 1'b1, big_mag(ri, rq), real_phase(ri, rq));
         spacing_chk = 1'b1;
      end
      spacing_chk = 1'b0;
      quiet();
      drain();

      // Random samples against the model
      for (int n = 0; n < 20; n++) begin
         rand_iq(ri, rq);
         send(ri, rq, 1'b0, big_mag(ri, rq), real_phase(ri, rq));
         drain();
      end

      // Burst of 8 with clken toggling randomly
      gate_en = 1'b1;
      fork
         begin
            while (gate_en) begin
               @(negedge clk);
               #1;
               clken = 1'($urandom_range(0, 1));
            end
            clken = 1'b1;
         end
      join_none
      for (int n = 0; n < 8; n++) begin
         rand_iq(ri, rq);
         send(ri, rq, 1'b0, big_mag(ri, rq), real_phase(ri, rq));
         drain();
      end
      gate_en = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in the middle of the rotations (k = 5)
      send(40000, -30000, 1'b0, 1'b0, 32'h0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_rst_phase", phase_o, 0);
      chk("async_rst_dphi", dphi_o, 0);
      chk("async_rst_dphi_valid", dphi_valid, 0);
      chk("async_rst_zero", zero_o, 0);
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_in_ready", in_ready, 0);
      exp_q.delete();
      m_prev = '0;
      m_have = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // NCO tone loopback; first result after reset has no previous phase
      tone_mode = 1'b1;
      p = '0;
      for (int n = 0; n < 10; n++) begin
         ri = int'(65535.0 * $cos(2.0 * PI * real'(p) / 4294967296.0));
         rq = int'(65535.0 * $sin(2.0 * PI * real'(p) / 4294967296.0));
         send(ri, rq, 1'b0, 1'b1, real_phase(ri, rq));
         drain();
         p = p + 32'h6A40_0000;
      end
      tone_mode = 1'b0;

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iq_phase_freq_meter.md
Name: iq_phase_freq_meter

Overview:
- Inverse of the NCO path: consumes a 17-bit signed cos/sin (I/Q) sample stream and recovers the instantaneous phase of each sample.
- Phase is recovered with an iterative CORDIC in vectoring mode.
- The block also outputs the per-sample phase increment, in the same 32-bit phi_inc format that drives the NCO.
- Sits after NCO/mixer outputs, for loopback self-test of NCO tuning and for FM/frequency-error measurement.

Parameters:
- IW, 17, input sample width (two's complement).
- PW, 32, phase width; 2^PW corresponds to 2π, unsigned.
- ITER, 16, number of CORDIC micro-rotations (1 per enabled clock).
- GW, 3, guard bits added to the internal x/y datapath (internal width IW+GW).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clken  in  1  global clock enable; when low all state freezes
- in_valid  in  1  sample strobe
- i_in  in  IW  cosine/I sample, signed
- q_in  in  IW  sine/Q sample, signed
- in_ready  out  1  block can accept a sample this cycle
- out_valid  out  1  one-cycle result strobe
- phase_o  out  PW  angle atan2(q,i), 0..2^PW-1
- dphi_o  out  PW  phase_o minus previous phase_o, modulo 2^PW
- dphi_valid  out  1  dphi_o is meaningful (a previous valid phase exists)
- zero_o  out  1  input was (0,0); phase undefined

Behaviour:
- Reset: in_ready=0 while reset_n low; all outputs 0; FSM in IDLE; prev-phase register cleared; have_prev=0. in_ready rises on the first clock after release, provided clken=1.
- All registers update only when clken=1. in_ready = (state==IDLE) & clken.
- Accept = in_valid & in_ready. Samples presented while not ready are ignored; the source holds the sample.
- FSM states:
  - IDLE: on accept, latch and sign-extend i/q to IW+GW bits, then go to PRE.
  - PRE: quadrant fold. If x<0: x=-x, y=-y, z=2^(PW-1). Otherwise z=0. Then go to ROT with k=0.
  - ROT: if y>=0: x+=y>>>k, y-=x>>>k, z+=atan_k. Else: x-=y>>>k, y+=x>>>k, z-=atan_k. k increments each cycle; after k=ITER-1, go to OUT. atan_k = round(atan(2^-k)·2^PW/2π), stored as a constant ROM (combinational case).
  - OUT: drive results and pulse out_valid, then go to IDLE.
- OUT results:
  - phase_o=z.
  - zero_o=1 iff the latched i=q=0. In that case phase_o=0, dphi_o=0, dphi_valid=0, and prev/have_prev are unchanged.
  - Otherwise dphi_o = z - prev mod 2^PW, and dphi_valid=have_prev. Then prev=z, have_prev=1.
- Latency: accept edge to out_valid = ITER+2 enabled cycles (18 by default). Throughput is 1 sample per ITER+3 enabled cycles. in_ready returns in the cycle after out_valid.
- phase_o, dphi_o, dphi_valid and zero_o hold their values until the next OUT. out_valid is low at all other times.
- Arithmetic: shifts are arithmetic. The z accumulator wraps modulo 2^PW; this wrap is intended. No overflow in x for |i|,|q| ≤ 2^(IW-1), since CORDIC gain 1.647·√2 < 2^GW.
- Accuracy: for magnitude ≥ 2^(IW-2), |phase error| ≤ 2^18 LSB (PW=32, ITER=16).
- Special cases:
  - -2^(IW-1) inputs are legal (guard bits absorb the negation).
  - clken low mid-ROT stalls k and all data; on resume, results are identical to the unstalled case.
  - reset_n asserted mid-operation aborts immediately. No out_valid is produced for the aborted sample, and have_prev=0.

Test Plan:
- Quadrant points: (i,q)=(65535,0) → phase ≈0x00000000 (±2^18, wrap-aware). (0,65535) → 0x40000000. (-65535,0) → 0x80000000. (0,-65535) → 0xC0000000. Each result arrives 18 cycles after accept.
- Tone recovery: drive the NCO with phi_inc 0x6A400000 and feed its cos/sin output to i_in/q_in.
  - First result: dphi_valid=0.
  - All following results: dphi_valid=1 and dphi_o = 0x6A400000 ±2^19.
- Handshake: hold in_valid=1 continuously. Accepts are spaced exactly 19 cycles apart, in_ready is low throughout processing, and out_valid is exactly one cycle wide.
- clken gating: toggle clken pseudo-randomly at 50% during a burst of 8 samples. Outputs match the ungated run bit-exactly, and out_valid never asserts while clken=0.
- Zero and extremes: (0,0) → zero_o=1, dphi_valid=0. Next sample (-65536,-65536) → phase ≈0xA0000000, no overflow, and dphi is computed against the last non-zero phase.
- Reset mid-ROT: assert reset_n low at k=5 → outputs go to 0 asynchronously. After release, the first result has dphi_valid=0.
